// File: rtl/wramp_pkg.sv
// Shared types and constants for the register write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wramp_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;
    localparam int NREGS  = 2 ** IDX_W;

    // r0 is hardwired; writes aimed at it are discarded
    localparam logic [IDX_W-1:0] R0 = '0;

    // One pending register-file write
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO of write-back requests, DEPTH a power of 2.
// Latency: a pushed entry becomes the head one cycle later at the earliest (no bypass).
// Backpressure: push ignored while full, pop ignored while empty; full/empty from registered count.
module wb_fifo
    import wramp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  wb_req_t                push_dat,
    input  logic                   pop_vld,
    output wb_req_t                head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Merges ALU results and queued MDU results onto the single register-file write port; tracks busy registers.
// Latency: 1 cycle from ALU result or FIFO pop to registered reg_write/wr_idx/wr_data.
// Backpressure: ALU never stalled (has priority); MDU stalled via mdu_ready when the FIFO is full.
module reg_writeback_ctrl
    import wramp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [IDX_W-1:0]       alu_idx,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [IDX_W-1:0]       mdu_idx,
    input  logic [DATA_W-1:0]      mdu_data,
    input  logic                   issue_valid,
    input  logic [IDX_W-1:0]       issue_idx,
    output logic [NREGS-1:0]       busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   reg_write,
    output logic [IDX_W-1:0]       wr_idx,
    output logic [DATA_W-1:0]      wr_data
);

    logic       alu_win;
    logic       push_vld;
    logic       pop_vld;
    logic       fifo_full;
    logic       fifo_empty;
    wb_req_t    push_dat;
    wb_req_t    head_dat;
    logic [NREGS-1:0] busy_nxt;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early
    assign mdu_ready = !fifo_full;

    // r0 results consume their slot/handshake but never reach the file
    assign alu_win  = alu_valid && (alu_idx != R0);
    assign push_vld = mdu_valid && mdu_ready && (mdu_idx != R0);
    assign pop_vld  = !alu_win && !fifo_empty;

    assign push_dat.idx  = mdu_idx;
    assign push_dat.data = mdu_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Scoreboard next state: pop clears, issue sets (set wins on collision), r0 never busy
    always_comb begin
        busy_nxt = busy;
        if (pop_vld) begin
            busy_nxt[head_dat.idx] = 1'b0;
        end
        if (issue_valid && (issue_idx != R0)) begin
            busy_nxt[issue_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Write-port arbitration: ALU over FIFO head; idle cycles hold idx/data
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write <= 1'b0;
            wr_idx    <= '0;
            wr_data   <= '0;
        end else if (alu_win) begin
            reg_write <= 1'b1;
            wr_idx    <= alu_idx;
            wr_data   <= alu_data;
        end else if (pop_vld) begin
            reg_write <= 1'b1;
            wr_idx    <= head_dat.idx;
            wr_data   <= head_dat.data;
        end else begin
            reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
module tb_reg_writeback_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_idx;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [3:0]  mdu_idx;
    logic [31:0] mdu_data;
    logic        issue_valid;
    logic [3:0]  issue_idx;
    logic [15:0] busy;
    logic [2:0]  fifo_count;
    logic        reg_write;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;

    int checks   = 0;
    int failures = 0;

    reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_idx     (alu_idx),
        .alu_data    (alu_data),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_idx     (mdu_idx),
        .mdu_data    (mdu_data),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .reg_write   (reg_write),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending MDU writes plus a busy bitmap
    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_busy  = '0;
    logic        m_write = 1'b0;
    logic [3:0]  m_idx   = '0;
    logic [31:0] m_data  = '0;
    bit          last_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst         = 1'b0;
        alu_valid   = 1'b0;
        alu_idx     = '0;
        alu_data    = '0;
        mdu_valid   = 1'b0;
        mdu_idx     = '0;
        mdu_data    = '0;
        issue_valid = 1'b0;
        issue_idx   = '0;
    endtask

    // One clock: check ready, advance the model, then compare every output
    task automatic tick();
        bit   ready_m;
        ent_t e;
        ready_m = (q.size() < DEPTH);
        check("mdu_ready", 64'(mdu_ready), 64'(ready_m));
        last_acc = mdu_valid && ready_m;
        if (rst) begin
            q.delete();
            m_busy  = '0;
            m_write = 1'b0;
            m_idx   = '0;
            m_data  = '0;
        end else begin
            if (alu_valid && alu_idx != 0) begin
                m_write = 1'b1;
                m_idx   = alu_idx;
                m_data  = alu_data;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_busy[e.idx] = 1'b0;
                m_write = 1'b1;
                m_idx   = e.idx;
                m_data  = e.data;
            end else begin
                m_write = 1'b0;
            end
            if (last_acc && mdu_idx != 0) begin
                e.idx  = mdu_idx;
                e.data = mdu_data;
                q.push_back(e);
            end
            if (issue_valid && issue_idx != 0) m_busy[issue_idx] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("reg_write",  64'(reg_write),  64'(m_write));
        check("wr_idx",     64'(wr_idx),     64'(m_idx));
        check("wr_data",    64'(wr_data),    64'(m_data));
        check("busy",       64'(busy),       64'(m_busy));
        check("fifo_count", 64'(fifo_count), 64'(q.size()));
    endtask

    task automatic offer(input logic [3:0] idx, input logic [31:0] data, input bit alu_on);
        alu_valid = alu_on;
        alu_idx   = 4'd1;
        alu_data  = 32'hA1A1_0000 + 32'(idx);
        mdu_valid = 1'b1;
        mdu_idx   = idx;
        mdu_data  = data;
        tick();
        mdu_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst0_reg_write", 64'(reg_write), 64'd0);
        check("rst0_count", 64'(fifo_count), 64'd0);

        // Mid-operation reset: 3 queued results, busy = 00F0
        for (int i = 0; i < 4; i++) begin
            idle();
            alu_valid   = 1'b1;
            alu_idx     = 4'd2;
            alu_data    = 32'(i);
            issue_valid = 1'b1;
            issue_idx   = 4'(4 + i);
            if (i < 3) begin
                mdu_valid = 1'b1;
                mdu_idx   = 4'(8 + i);
                mdu_data  = 32'h100 + 32'(i);
            end
            tick();
        end
        check("pre_rst_busy", 64'(busy), 64'h00F0);
        check("pre_rst_count", 64'(fifo_count), 64'd3);
        idle();
        rst = 1'b1;
        tick();
        idle();
        check("rst_reg_write", 64'(reg_write), 64'd0);
        check("rst_wr_idx", 64'(wr_idx), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ready", 64'(mdu_ready), 64'd1);
        tick();
        check("post_rst_no_write", 64'(reg_write), 64'd0);

        // ALU path, then ALU to r0 dropped
        alu_valid = 1'b1; alu_idx = 4'd5; alu_data = 32'hDEADBEEF;
        tick();
        check("alu_we", 64'(reg_write), 64'd1);
        check("alu_idx", 64'(wr_idx), 64'd5);
        check("alu_data", 64'(wr_data), 64'hDEADBEEF);
        alu_idx = 4'd0;
        tick();
        check("alu_r0_dropped", 64'(reg_write), 64'd0);
        idle();

        // Priority and ordering
        issue_valid = 1'b1; issue_idx = 4'd3;
        tick();
        idle();
        check("busy3_set", 64'(busy[3]), 64'd1);
        alu_valid = 1'b1; alu_idx = 4'd6; alu_data = 32'hA0;
        mdu_valid = 1'b1; mdu_idx = 4'd3; mdu_data = 32'h11;
        tick();
        check("prio_alu1", 64'(wr_idx), 64'd6);
        mdu_idx = 4'd7; mdu_data = 32'h22; alu_data = 32'hA1;
        tick();
        check("prio_alu2", 64'(wr_data), 64'hA1);
        mdu_valid = 1'b0; alu_data = 32'hA2;
        tick();
        check("prio_alu3", 64'(wr_data), 64'hA2);
        idle();
        tick();
        check("prio_mdu1_idx", 64'(wr_idx), 64'd3);
        check("prio_mdu1_data", 64'(wr_data), 64'h11);
        check("busy3_clear", 64'(busy[3]), 64'd0);
        tick();
        check("prio_mdu2_idx", 64'(wr_idx), 64'd7);
        check("prio_mdu2_data", 64'(wr_data), 64'h22);
        drain();

        // Full FIFO with held 5th offer, wrap over 8 entries
        for (int i = 0; i < 4; i++) offer(4'(8 + i), 32'hF00 + 32'(i), 1'b1);
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(mdu_ready), 64'd0);
        begin
            int n = 0;
            alu_valid = 1'b1; alu_idx = 4'd1; alu_data = 32'h55;
            mdu_valid = 1'b1; mdu_idx = 4'd12; mdu_data = 32'hF04;
            tick();
            check("held_not_taken", 64'(fifo_count), 64'd4);
            alu_valid = 1'b0;
            do begin
                tick();
                n++;
            end while (!last_acc && n < 20);
            check("held_accepted", 64'(last_acc), 64'd1);
            mdu_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) offer(4'(13 + i), 32'hF05 + 32'(i), 1'b0);
        drain();

        // Scoreboard race: issue 9 on the same edge the FIFO pops idx 9
        offer(4'd9, 32'h99, 1'b1);
        issue_valid = 1'b1; issue_idx = 4'd9;
        tick();
        check("race_pop9", 64'(wr_idx), 64'd9);
        check("race_busy9", 64'(busy[9]), 64'd1);
        issue_idx = 4'd0;
        tick();
        check("busy0_zero", 64'(busy[0]), 64'd0);
        drain();

        // Push and pop together at count 2
        offer(4'd2, 32'hC2, 1'b1);
        offer(4'd3, 32'hC3, 1'b1);
        check("pp_pre_count", 64'(fifo_count), 64'd2);
        offer(4'd4, 32'hC4, 1'b0);
        check("pp_count", 64'(fifo_count), 64'd2);
        check("pp_head_idx", 64'(wr_idx), 64'd2);
        check("pp_head_data", 64'(wr_data), 64'hC2);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            alu_valid   = ($urandom_range(0, 99) < 45);
            alu_idx     = 4'($urandom_range(0, 15));
            alu_data    = $urandom;
            mdu_valid   = ($urandom_range(0, 99) < 55);
            mdu_idx     = 4'($urandom_range(0, 15));
            mdu_data    = $urandom;
            issue_valid = ($urandom_range(0, 99) < 40);
            issue_idx   = 4'($urandom_range(0, 15));
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
Write-side controller for the 16 x 32-bit register file. It merges single-cycle ALU results and multi-cycle MDU (mul/div) results into the file's single write port: reg_write, wr_idx, wr_data. MDU results wait in a small FIFO. A per-register busy scoreboard lets decode stall on registers with an outstanding MDU write. It sits between the execute/MDU outputs and the register file.

Parameters:
DATA_W, 32, register data width
IDX_W, 4, register index width
NREGS, 16, number of registers (2**IDX_W)
DEPTH, 4, MDU result FIFO depth (power of 2, >= 2)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
alu_valid  in  1  ALU result present this cycle (cannot be back-pressured)
alu_idx  in  IDX_W  ALU destination register
alu_data  in  DATA_W  ALU result
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  MDU result accepted when mdu_valid && mdu_ready
mdu_idx  in  IDX_W  MDU destination register
mdu_data  in  DATA_W  MDU result
issue_valid  in  1  multi-cycle op issued this cycle; mark destination busy
issue_idx  in  IDX_W  destination of the issued op
busy  out  NREGS  scoreboard; bit i = register i has a pending MDU write
fifo_count  out  log2(DEPTH)+1  current MDU FIFO occupancy
reg_write  out  1  register-file write enable (registered)
wr_idx  out  IDX_W  register-file write index (registered)
wr_data  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (rst=1 at posedge): reg_write=0, wr_idx=0, wr_data=0, busy=0, FIFO emptied (fifo_count=0). Reset in mid-operation discards all queued MDU results and busy bits. No write issues in the cycle after reset.
- Write selection each cycle. Priority is ALU > FIFO head.
  - ALU wins: if alu_valid && alu_idx!=0, next cycle reg_write=1, wr_idx=alu_idx, wr_data=alu_data. Latency is 1 cycle.
  - Otherwise, if the FIFO is non-empty: pop the head; next cycle reg_write=1 with the head's idx and data.
  - Otherwise: reg_write=0, and wr_idx/wr_data hold their previous values.
- An ALU result to r0 is dropped. It does not block the FIFO, so the FIFO may pop in that cycle.
- MDU handshake:
  - mdu_ready = (fifo_count < DEPTH). It is computed only from registered count, with no combinational path from the same-cycle pop.
  - When the FIFO is full, a same-cycle pop does not admit a push.
  - Accepting an MDU result for idx 0 consumes the handshake but is not enqueued.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - A result pushed in cycle N can be popped no earlier than cycle N+1. An empty FIFO does not bypass.
- Scoreboard:
  - issue_valid && issue_idx!=0 sets busy[issue_idx] at the next edge.
  - A FIFO pop of idx k clears busy[k] at the same edge the write is registered.
  - If a set and a clear hit the same index in the same cycle, set wins.
  - busy[0] is always 0.
- Ordering: MDU results are written in acceptance order. ALU writes may overtake queued MDU writes. Decode must stall on busy to avoid WAW hazards; this block does not check.
- Starvation: continuous alu_valid starves the FIFO by design. Decode guarantees bubbles.
- Arithmetic: fifo_count has log2(DEPTH)+1 bits. It never exceeds DEPTH and never underflows.

Decomposition:
- Shared package (wramp_pkg): DATA_W, IDX_W, NREGS constants; R0 index constant; wb_req_t struct {idx, data}.
- One sub-module: wb_fifo (parameterised DEPTH synchronous FIFO holding wb_req_t, with push/pop/count/full/empty).
- Arbitration and scoreboard stay in the top level.

Test Plan:
- Reset check: assert rst with FIFO holding 3 entries and busy=16'h00F0 -> next cycle reg_write=0, wr_idx=0, wr_data=0, busy=0, fifo_count=0, mdu_ready=1.
- ALU path: alu_valid, idx=5, data=32'hDEADBEEF in cycle N -> cycle N+1 reg_write=1, wr_idx=5, wr_data=32'hDEADBEEF. Same stimulus with idx=0 -> reg_write=0.
- MDU priority and ordering:
  - issue idx 3, then push MDU (3, 32'h11) and (7, 32'h22) while alu_valid is held for 3 cycles.
  - Required: ALU writes first, then idx 3/32'h11, then idx 7/32'h22.
  - busy[3] clears on the edge that registers the idx 3 write.
- Full FIFO: push 4 MDU results with the ALU busy -> fifo_count=4, mdu_ready=0. A 5th offer is held until a pop, then accepted. Pointers wrap, and data order is preserved across 8 total entries.
- Scoreboard race: issue_valid idx 9 in the same cycle the FIFO pops a result for idx 9 -> busy[9]=1 afterwards. issue idx 0 -> busy[0] stays 0.
- Push and pop in the same cycle at count=2 -> count stays 2, and the head data is written correctly.
